// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction/flag inputs and control strobes between datapath and controller
interface multicycle_ctrl_if;
  logic [31:0] instr;
  logic        Zero;
  logic        PCSrc;
  logic        ALUSrc;
  logic        RegWrite;
  logic        MemToReg;
  logic [3:0]  ALUCtrl;
  logic        loadPC;
  logic        MemRead;
  logic        MemWrite;
  logic        illegal;
  logic [2:0]  state;
  modport master (
    output instr, Zero,
    input  PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC, MemRead, MemWrite, illegal, state
  );
  modport slave (
    input  instr, Zero,
    output PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC, MemRead, MemWrite, illegal, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: five-state multicycle RISC-V control FSM with registered strobes
module multicycle_ctrl (
  input logic clk,
  input logic rst,
  multicycle_ctrl_if.slave bus
);
  typedef enum logic [2:0] {S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4} state_t;
  localparam logic [3:0] AND_OP = 4'b0000, OR_OP = 4'b0001, ADD_OP = 4'b0010, SUB_OP = 4'b0110,
                         SLT_OP = 4'b0111, SRL_OP = 4'b1000, SLL_OP = 4'b1001, SRA_OP = 4'b1010,
                         XOR_OP = 4'b1101;
  state_t st, nx;
  logic [6:0] op, op_n;
  logic [2:0] f3, f3_n;
  logic f7, f7_n;
  logic is_r, is_i, is_lw, is_sw, is_beq, ill, exec;
  logic [3:0] alu_n;
  logic br;
  function automatic logic [3:0] alu_dec(input logic [2:0] f, input logic b);
    case (f)
      3'b000:  return b ? SUB_OP : ADD_OP;
      3'b001:  return SLL_OP;
      3'b010:  return SLT_OP;
      3'b100:  return XOR_OP;
      3'b101:  return b ? SRA_OP : SRL_OP;
      3'b110:  return OR_OP;
      3'b111:  return AND_OP;
      default: return ADD_OP;
    endcase
  endfunction
  // In IF the fields are being captured this edge, so decode straight from instr
  always_comb begin
    op_n   = st == S_IF ? bus.instr[6:0]   : op;
    f3_n   = st == S_IF ? bus.instr[14:12] : f3;
    f7_n   = st == S_IF ? bus.instr[30]    : f7;
    is_r   = op_n == 7'b0110011;
    is_i   = op_n == 7'b0010011;
    is_lw  = op_n == 7'b0000011;
    is_sw  = op_n == 7'b0100011;
    is_beq = op_n == 7'b1100011;
    ill    = !(is_r || is_i || is_lw || is_sw || is_beq);
    nx     = st == S_IF  ? S_ID :
             st == S_ID  ? (ill ? S_IF : S_EX) :
             st == S_EX  ? (is_beq ? S_IF : (is_lw || is_sw) ? S_MEM : S_WB) :
             st == S_MEM ? (is_lw ? S_WB : S_IF) : S_IF;
    exec   = nx == S_EX || nx == S_MEM || nx == S_WB;
    alu_n  = is_r   ? alu_dec(f3_n, f7_n) :
             is_i   ? (f3_n == 3'b000 ? ADD_OP : alu_dec(f3_n, f7_n)) :
             is_beq ? SUB_OP : ADD_OP;
  end
  // Strobes are registered for the state being entered
  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= S_IF;
      op           <= '0;
      f3           <= '0;
      f7           <= 1'b0;
      br           <= 1'b0;
      bus.ALUSrc   <= 1'b0;
      bus.RegWrite <= 1'b0;
      bus.MemToReg <= 1'b0;
      bus.ALUCtrl  <= ADD_OP;
      bus.loadPC   <= 1'b0;
      bus.MemRead  <= 1'b0;
      bus.MemWrite <= 1'b0;
      bus.illegal  <= 1'b0;
    end else begin
      st <= nx;
      if (st == S_IF) begin
        op <= op_n;
        f3 <= f3_n;
        f7 <= f7_n;
      end
      br           <= nx == S_EX && is_beq;
      bus.ALUSrc   <= (nx == S_EX || nx == S_MEM) && (is_i || is_lw || is_sw);
      bus.RegWrite <= nx == S_WB;
      bus.MemToReg <= nx == S_WB && is_lw;
      bus.ALUCtrl  <= exec ? alu_n : ADD_OP;
      bus.loadPC   <= nx == S_WB || (nx == S_MEM && is_sw) || (nx == S_EX && is_beq) || (nx == S_ID && ill);
      bus.MemRead  <= nx == S_MEM && is_lw;
      bus.MemWrite <= nx == S_MEM && is_sw;
      bus.illegal  <= nx == S_ID && ill;
    end
  end
  assign bus.PCSrc = br & bus.Zero;
  assign bus.state = st;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed per-cycle checks of state and every control output
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  localparam logic [3:0] A = 4'b0010, S = 4'b0110, SRA = 4'b1010;
  multicycle_ctrl_if bus ();
  multicycle_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [14:0] obs;
  assign obs = {bus.state, bus.PCSrc, bus.ALUSrc, bus.RegWrite, bus.MemToReg, bus.ALUCtrl,
                bus.loadPC, bus.MemRead, bus.MemWrite, bus.illegal};
  // {state, PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC, MemRead, MemWrite, illegal}
  function automatic logic [14:0] v(input logic [2:0] s, input logic pcs, input logic as,
                                    input logic rw, input logic m2r, input logic [3:0] alu,
                                    input logic lpc, input logic mr, input logic mw, input logic il);
    return {s, pcs, as, rw, m2r, alu, lpc, mr, mw, il};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic [14:0] e);
    check(tag, {17'd0, obs}, {17'd0, e});
    @(posedge clk);
    #1;
  endtask
  // Fetch and decode; instr is scrambled after IF to prove it is captured
  task automatic fetch(input string tag, input logic [31:0] w);
    bus.instr = w;
    cyc({tag, "_if"}, v(0, 0, 0, 0, 0, A, 0, 0, 0, 0));
    bus.instr = 32'h0000007F;
    cyc({tag, "_id"}, v(1, 0, 0, 0, 0, A, 0, 0, 0, 0));
  endtask
  task automatic alu_run(input string tag, input logic [31:0] w, input logic imm, input logic [3:0] alu);
    fetch(tag, w);
    cyc({tag, "_ex"}, v(2, 0, imm, 0, 0, alu, 0, 0, 0, 0));
    cyc({tag, "_wb"}, v(4, 0, 0, 1, 0, alu, 1, 0, 0, 0));
  endtask
  task automatic beq_run(input string tag, input logic z);
    bus.Zero = z;
    fetch(tag, 32'h00208463);
    cyc({tag, "_ex"}, v(2, z, 0, 0, 0, S, 1, 0, 0, 0));
    bus.Zero = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    bus.instr = 32'h0;
    bus.Zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc("reset", v(0, 0, 0, 0, 0, A, 0, 0, 0, 0));
    rst = 1'b0;
    alu_run("add", 32'h002081B3, 1'b0, A);
    fetch("lw", 32'h0080A283);
    cyc("lw_ex", v(2, 0, 1, 0, 0, A, 0, 0, 0, 0));
    cyc("lw_mem", v(3, 0, 1, 0, 0, A, 0, 1, 0, 0));
    cyc("lw_wb", v(4, 0, 0, 1, 1, A, 1, 0, 0, 0));
    fetch("sw", 32'h0050A223);
    cyc("sw_ex", v(2, 0, 1, 0, 0, A, 0, 0, 0, 0));
    cyc("sw_mem", v(3, 0, 1, 0, 0, A, 1, 0, 1, 0));
    beq_run("beq_z1", 1'b1);
    beq_run("beq_z0", 1'b0);
    bus.instr = 32'h0000007F;
    cyc("ill_if", v(0, 0, 0, 0, 0, A, 0, 0, 0, 0));
    cyc("ill_id", v(1, 0, 0, 0, 0, A, 1, 0, 0, 1));
    alu_run("sub", 32'h402081B3, 1'b0, S);
    alu_run("sra", 32'h4020D1B3, 1'b0, SRA);
    alu_run("addi_b30", 32'hC0008093, 1'b1, A);
    alu_run("srai", 32'h4030D093, 1'b1, SRA);
    fetch("lw_rst", 32'h0080A283);
    cyc("lw_rst_ex", v(2, 0, 1, 0, 0, A, 0, 0, 0, 0));
    check("lw_rst_mem", {17'd0, obs}, {17'd0, v(3, 0, 1, 0, 0, A, 0, 1, 0, 0)});
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid", {17'd0, obs}, {17'd0, v(0, 0, 0, 0, 0, A, 0, 0, 0, 0)});
    rst = 1'b0;
    alu_run("post_rst_add", 32'h002081B3, 1'b0, A);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have no parameters; the opcode and ALUCtrl encodings in this document are fixed.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 instr  input  32  current instruction word; SHALL be valid during IF.
REQ-005 Zero  input  1  ALU zero flag from datapath; SHALL be valid during EX.
REQ-006 PCSrc  output  1  1 selects the branch target, 0 selects PC+4.
REQ-007 ALUSrc  output  1  1 selects the immediate as ALU operand 2.
REQ-008 RegWrite  output  1  register file write enable.
REQ-009 MemToReg  output  1  1 selects memory read data for writeback.
REQ-010 ALUCtrl  output  4  ALU operation code.
REQ-011 loadPC  output  1  PC update strobe.
REQ-012 MemRead  output  1  data memory read strobe.
REQ-013 MemWrite  output  1  data memory write strobe.
REQ-014 illegal  output  1  one-cycle pulse on an unsupported opcode.
REQ-015 state  output  3  current FSM state, for debug.

Function
REQ-016 The FSM SHALL use these states and encodings: IF=0, ID=1, EX=2, MEM=3, WB=4; values 5-7 SHALL transition to IF on the next cycle.
REQ-017 In IF, the block SHALL capture instr[6:0] (opcode), instr[14:12] (funct3) and instr[30] (funct7b5) into internal registers; those registers SHALL be used for decode in all later states, and later changes to instr SHALL be ignored.
REQ-018 Supported opcodes SHALL be: R=0110011, I-ALU=0010011, LW=0000011, SW=0100011, BEQ=1100011.
REQ-019 The state sequence for each class SHALL be: R and I-ALU IF->ID->EX->WB->IF; LW IF->ID->EX->MEM->WB->IF; SW IF->ID->EX->MEM->IF; BEQ IF->ID->EX->IF.
REQ-020 An unsupported opcode SHALL follow IF->ID->IF, with illegal=1 and loadPC=1 during ID and no RegWrite or memory strobe for that instruction.
REQ-021 loadPC SHALL be 1 for exactly one cycle per instruction, in its final state: WB for R, I-ALU and LW; MEM for SW; EX for BEQ; ID for illegal.
REQ-022 PCSrc SHALL equal Zero in EX for BEQ and SHALL be 0 in every other cycle.
REQ-023 ALUSrc SHALL be 1 in EX and MEM for I-ALU, LW and SW, and 0 otherwise.
REQ-024 RegWrite SHALL be 1 only in WB; MemToReg SHALL be 1 only in WB for LW.
REQ-025 MemRead SHALL be 1 only in MEM for LW; MemWrite SHALL be 1 only in MEM for SW.
REQ-026 ALUCtrl encodings SHALL be: AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, SRL=1000, SLL=1001, SRA=1010, XOR=1101.
REQ-027 ALUCtrl for R-type SHALL decode from funct3 and funct7b5 as follows: 000 gives ADD, or SUB when funct7b5=1; 001 gives SLL; 010 gives SLT; 100 gives XOR; 101 gives SRL, or SRA when funct7b5=1; 110 gives OR; 111 gives AND; any other funct3 gives ADD.
REQ-028 ALUCtrl for I-ALU SHALL decode the same way, except that funct3=000 SHALL always give ADD.
REQ-029 ALUCtrl SHALL be ADD for LW and SW, and SUB for BEQ.
REQ-030 ALUCtrl SHALL hold its decoded value from EX through the end of the instruction, and SHALL be ADD in IF and ID.
REQ-031 All outputs SHALL be Moore functions of state and the captured fields; no output SHALL depend combinationally on instr.

Reset
REQ-032 While rst=1 on a rising edge, state SHALL become IF, the captured fields SHALL clear to 0, and all strobes (loadPC, RegWrite, MemRead, MemWrite, illegal, PCSrc) SHALL be 0 from the next cycle.
REQ-033 Reset asserted in any state, including mid-instruction, SHALL abort that instruction with no further strobes; fetch SHALL resume in IF on the first cycle after rst deasserts.

Verification
REQ-034 add x3,x1,x2 (0x002081B3) -> states 0,1,2,4; ALUCtrl=0010; RegWrite=1 and loadPC=1 only in cycle 4.
REQ-035 lw x5,8(x1) (0x0080A283) -> states 0,1,2,3,4; ALUSrc=1 in EX and MEM; MemRead=1 in MEM; MemToReg=1 and RegWrite=1 in WB.
REQ-036 sw x5,4(x1) (0x0050A223) -> states 0,1,2,3,0; MemWrite=1 and loadPC=1 in MEM; RegWrite never asserted.
REQ-037 beq with Zero=1 in EX -> PCSrc=1, loadPC=1, ALUCtrl=0110, next state IF; repeated with Zero=0 -> PCSrc=0.
REQ-038 Opcode 1111111 -> illegal=1 and loadPC=1 in ID, no write strobes, next state IF; sub/sra instructions -> ALUCtrl 0110 and 1010.
REQ-039 rst asserted during MEM of an lw -> no WB cycle, all strobes 0, state=IF after the reset edge.
